// File: rtl/razor_recovery_ctrl_pkg.sv
// Shared types and constants for the Razor error recovery controller.
// Holds the state encoding, stage indices and the saturating counter helper.
package razor_recovery_ctrl_pkg;

   localparam int PC_W  = 32;
   localparam int CNT_W = 16;

   localparam int STG_IFID  = 0;
   localparam int STG_IDEX  = 1;
   localparam int STG_EXMEM = 2;
   localparam int STG_MEMWB = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FLUSH    = 3'd1,
      ST_REDIRECT = 3'd2,
      ST_GUARD    = 3'd3,
      ST_HALT     = 3'd4
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/razor_recovery_ctrl_if.sv
// Bundle between the recovery controller and the Razor-protected pipeline.
// master = controller side, slave = pipeline/fetch side.
interface razor_recovery_ctrl_if
   import razor_recovery_ctrl_pkg::*;
#(
   parameter int NSTAGE = 4
) ();
   logic [NSTAGE-1:0]      err_in;
   logic [PC_W*NSTAGE-1:0] stage_pc;
   logic                   flush;
   logic                   stall;
   logic                   pc_load;
   logic [PC_W-1:0]        pc_target;
   logic                   recovering;
   logic                   fatal;
   logic [CNT_W-1:0]       err_count;

   modport master (
      input  err_in, stage_pc,
      output flush, stall, pc_load, pc_target, recovering, fatal, err_count
   );

   modport slave (
      output err_in, stage_pc,
      input  flush, stall, pc_load, pc_target, recovering, fatal, err_count
   );
endinterface

// File: rtl/razor_recovery_ctrl_err_prio.sv
// Combinational oldest-stage select: highest asserted err bit picks its PC slice.
module razor_err_prio
   import razor_recovery_ctrl_pkg::*;
#(
   parameter int NSTAGE = 4
) (
   input  logic [NSTAGE-1:0]      i_err,
   input  logic [PC_W*NSTAGE-1:0] i_stage_pc,
   output logic                   o_any_err,
   output logic [PC_W-1:0]        o_sel_pc
);

   always_comb begin
      o_any_err = |i_err;
      o_sel_pc  = '0;
      // Ascending scan so the oldest (highest index) stage overrides younger ones
      for (int i = 0; i < NSTAGE; i++) begin
         if (i_err[i]) o_sel_pc = i_stage_pc[PC_W*i +: PC_W];
      end
   end

endmodule

// File: rtl/razor_recovery_ctrl.sv
// Razor recovery sequencer: accept error, flush, redirect PC, guard refill,
// escalating to a sticky HALT after too many back-to-back recoveries.
module razor_recovery_ctrl
   import razor_recovery_ctrl_pkg::*;
#(
   parameter int NSTAGE       = 4,
   parameter int GUARD_CYCLES = 4,
   parameter int MAX_RETRY    = 3
) (
   input logic                  clk,
   input logic                  reset,
   razor_recovery_ctrl_if.master bus
);

   localparam logic [3:0] LP_GUARD = 4'(GUARD_CYCLES);
   localparam logic [3:0] LP_RETRY = 4'(MAX_RETRY);

   logic             w_any_err;
   logic [PC_W-1:0]  w_sel_pc;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_guard, w_guard_nxt;
   logic [3:0]       r_retry, w_retry_nxt;
   logic             w_accept;

   logic             r_flush, r_stall, r_pc_load, r_recovering, r_fatal;
   logic [PC_W-1:0]  r_pc_target;
   logic [CNT_W-1:0] r_err_count;

   razor_err_prio #(.NSTAGE(NSTAGE)) u_prio (
      .i_err      (bus.err_in),
      .i_stage_pc (bus.stage_pc),
      .o_any_err  (w_any_err),
      .o_sel_pc   (w_sel_pc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_guard_nxt = r_guard;
      w_retry_nxt = r_retry;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_err) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH:    w_state_nxt = ST_REDIRECT;
         ST_REDIRECT: begin
            w_state_nxt = ST_GUARD;
            w_guard_nxt = LP_GUARD;
         end
         ST_GUARD: begin
            if (w_any_err) begin
               w_accept    = 1'b1;
               w_retry_nxt = r_retry + 4'd1;
               w_state_nxt = (w_retry_nxt > LP_RETRY) ? ST_HALT : ST_FLUSH;
            end else if (r_guard <= 4'd1) begin
               w_state_nxt = ST_IDLE;
               w_retry_nxt = '0;
               w_guard_nxt = '0;
            end else begin
               w_guard_nxt = r_guard - 4'd1;
            end
         end
         ST_HALT:     w_state_nxt = ST_HALT;
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they align with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_guard      <= '0;
         r_retry      <= '0;
         r_flush      <= 1'b0;
         r_stall      <= 1'b0;
         r_pc_load    <= 1'b0;
         r_recovering <= 1'b0;
         r_fatal      <= 1'b0;
         r_pc_target  <= '0;
         r_err_count  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_guard      <= w_guard_nxt;
         r_retry      <= w_retry_nxt;
         r_flush      <= (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_HALT);
         r_stall      <= (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_REDIRECT) ||
                         (w_state_nxt == ST_HALT);
         r_pc_load    <= (w_state_nxt == ST_REDIRECT);
         r_recovering <= (w_state_nxt != ST_IDLE);
         r_fatal      <= (w_state_nxt == ST_HALT);
         if (w_accept) begin
            r_pc_target <= w_sel_pc;
            r_err_count <= sat_inc(r_err_count);
         end
      end
   end

   assign bus.flush      = r_flush;
   assign bus.stall      = r_stall;
   assign bus.pc_load    = r_pc_load;
   assign bus.pc_target  = r_pc_target;
   assign bus.recovering = r_recovering;
   assign bus.fatal      = r_fatal;
   assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_razor_recovery_ctrl.sv
// Directed bench for razor_recovery_ctrl (NSTAGE=4, GUARD_CYCLES=4, MAX_RETRY=3).
module tb_razor_recovery_ctrl;
   import razor_recovery_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   razor_recovery_ctrl_if #(.NSTAGE(4)) bus ();

   razor_recovery_ctrl #(.NSTAGE(4), .GUARD_CYCLES(4), .MAX_RETRY(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pc(input int idx, input logic [31:0] v);
      bus.stage_pc[32*idx +: 32] = v;
   endtask

   task automatic nedge();
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.recovering !== 1'b0 && n < 20) begin
         nedge();
         n++;
      end
      chk(tag, {31'd0, bus.recovering}, 32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      bus.err_in   = '0;
      bus.stage_pc = '0;
      nedge(); nedge();
      chk("rst_flush", {31'd0, bus.flush}, 0);
      chk("rst_stall", {31'd0, bus.stall}, 0);
      chk("rst_pcload", {31'd0, bus.pc_load}, 0);
      chk("rst_recov", {31'd0, bus.recovering}, 0);
      chk("rst_fatal", {31'd0, bus.fatal}, 0);
      chk("rst_pct", bus.pc_target, 0);
      chk("rst_cnt", {16'd0, bus.err_count}, 0);
      reset = 1'b0;
      nedge();

      // 1: single error from EX/MEM
      set_pc(2, 32'h40); bus.err_in = 4'b0100;
      nedge(); bus.err_in = '0;
      chk("t1_flush", {31'd0, bus.flush}, 1);
      chk("t1_stall", {31'd0, bus.stall}, 1);
      chk("t1_noload", {31'd0, bus.pc_load}, 0);
      chk("t1_cnt", {16'd0, bus.err_count}, 1);
      nedge();
      chk("t1_pcload", {31'd0, bus.pc_load}, 1);
      chk("t1_redir_flush", {31'd0, bus.flush}, 0);
      chk("t1_pct", bus.pc_target, 32'h40);
      for (int i = 0; i < 4; i++) begin
         nedge();
         chk("t1_guard_recov", {31'd0, bus.recovering}, 1);
         chk("t1_guard_stall", {31'd0, bus.stall}, 0);
      end
      nedge();
      chk("t1_idle", {31'd0, bus.recovering}, 0);

      // 2: two stages at once, oldest wins, counted once
      set_pc(3, 32'h100); set_pc(1, 32'h108); bus.err_in = 4'b1010;
      nedge(); bus.err_in = '0;
      chk("t2_pct", bus.pc_target, 32'h100);
      chk("t2_cnt", {16'd0, bus.err_count}, 2);
      wait_idle("t2_idle");

      // 3: errors during FLUSH and REDIRECT are ignored
      set_pc(0, 32'h300); bus.err_in = 4'b0001;
      nedge();
      set_pc(0, 32'h304);
      chk("t3_flush", {31'd0, bus.flush}, 1);
      nedge();
      chk("t3_pcload", {31'd0, bus.pc_load}, 1);
      chk("t3_cnt_redir", {16'd0, bus.err_count}, 3);
      nedge(); bus.err_in = '0;
      chk("t3_single_load", {31'd0, bus.pc_load}, 0);
      chk("t3_pct", bus.pc_target, 32'h300);
      chk("t3_cnt", {16'd0, bus.err_count}, 3);
      wait_idle("t3_idle");

      // 4: new error in second GUARD cycle re-enters FLUSH
      set_pc(0, 32'h400); bus.err_in = 4'b0001;
      nedge(); bus.err_in = '0;
      nedge(); nedge(); nedge();
      set_pc(2, 32'h200); bus.err_in = 4'b0100;
      nedge(); bus.err_in = '0;
      chk("t4_reflush", {31'd0, bus.flush}, 1);
      chk("t4_pct", bus.pc_target, 32'h200);
      chk("t4_cnt", {16'd0, bus.err_count}, 5);
      chk("t4_retry", {28'd0, dut.r_retry}, 1);
      wait_idle("t4_idle");
      chk("t4_retry_clr", {28'd0, dut.r_retry}, 0);
      set_pc(1, 32'h220); bus.err_in = 4'b0010;
      nedge(); bus.err_in = '0;
      chk("t4_later_nofatal", {31'd0, bus.fatal}, 0);
      chk("t4_later_cnt", {16'd0, bus.err_count}, 6);
      wait_idle("t4_idle2");

      // 5: error in every GUARD window until HALT
      set_pc(3, 32'h600); bus.err_in = 4'b1000;
      nedge(); bus.err_in = '0;
      for (int k = 1; k <= 4; k++) begin
         nedge(); nedge();
         bus.err_in = 4'b1000;
         nedge(); bus.err_in = '0;
         chk("t5_fatal", {31'd0, bus.fatal}, (k == 4) ? 1 : 0);
         chk("t5_flush", {31'd0, bus.flush}, 1);
      end
      chk("t5_cnt", {16'd0, bus.err_count}, 11);
      bus.err_in = 4'b1111;
      repeat (5) nedge();
      chk("t5_hold_fatal", {31'd0, bus.fatal}, 1);
      chk("t5_hold_stall", {31'd0, bus.stall}, 1);
      chk("t5_hold_flush", {31'd0, bus.flush}, 1);
      chk("t5_hold_noload", {31'd0, bus.pc_load}, 0);
      chk("t5_hold_cnt", {16'd0, bus.err_count}, 11);
      bus.err_in = '0;
      #2 reset = 1'b1;
      #1 chk("t5_rst_fatal", {31'd0, bus.fatal}, 0);
      nedge(); reset = 1'b0;

      // 6: asynchronous reset mid-GUARD, then saturated counter
      set_pc(0, 32'h700); bus.err_in = 4'b0001;
      nedge(); bus.err_in = '0;
      nedge(); nedge();
      chk("t6_in_guard", {31'd0, bus.recovering}, 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_arst_recov", {31'd0, bus.recovering}, 0);
      chk("t6_arst_cnt", {16'd0, bus.err_count}, 0);
      chk("t6_arst_pct", bus.pc_target, 0);
      nedge();
      chk("t6_arst_noflush", {31'd0, bus.flush}, 0);
      reset = 1'b0;
      nedge();
      force dut.r_err_count = 16'hFFFF;
      #1 release dut.r_err_count;
      set_pc(2, 32'h500); bus.err_in = 4'b0100;
      nedge(); bus.err_in = '0;
      chk("t6_sat_cnt", {16'd0, bus.err_count}, 32'hFFFF);
      chk("t6_sat_flush", {31'd0, bus.flush}, 1);
      chk("t6_sat_pct", bus.pc_target, 32'h500);
      nedge();
      chk("t6_sat_pcload", {31'd0, bus.pc_load}, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/razor_recovery_ctrl.md
Name: razor_recovery_ctrl

Overview:
Central consumer of the Razor error indications that each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) raises on its errorout with the matching pcout.
- Selects the oldest erroring stage and captures its PC.
- Sequences recovery: flush the pipeline registers, redirect the PC, then hold a guard window while the pipeline refills.
- Escalates to a sticky fatal flag on repeated failure.
- Drives the errorin of every pipeline register and the PC-select logic in the fetch stage.

Parameters:
NSTAGE, 4, number of Razor-protected pipeline registers; index 0 = IF/ID (youngest), NSTAGE-1 = MEM/WB (oldest).
GUARD_CYCLES, 4, refill cycles after redirect before returning to idle; range 1..15.
MAX_RETRY, 3, back-to-back recoveries allowed before fatal; range 1..7.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
err_in  input  NSTAGE  per-stage errorout; bit i from stage i
stage_pc  input  32*NSTAGE  per-stage pcout; bits [32i+31:32i] belong to stage i
flush  output  1  drives errorin of all pipeline registers
stall  output  1  freezes PC register and fetch
pc_load  output  1  one-cycle strobe: PC register loads pc_target
pc_target  output  32  replay PC
recovering  output  1  high in any state other than IDLE
fatal  output  1  sticky unrecoverable-error flag
err_count  output  16  saturating count of accepted errors

Behaviour:
- All outputs are registered. Reset (async, active-high) forces:
  - state IDLE
  - flush, stall, pc_load, recovering, fatal = 0
  - pc_target = 0, err_count = 0, retry counter = 0, guard counter = 0
- Stage priority: the highest-index asserted err_in bit wins, because the oldest instruction is replayed first. Its stage_pc slice is captured into pc_target at the accepting edge.
- FSM states: IDLE, FLUSH, REDIRECT, GUARD, HALT.
- IDLE:
  - If err_in != 0 at edge N, capture the PC, increment err_count (saturates at 0xFFFF), and go to FLUSH.
  - Outputs during cycle N+1: flush=1, stall=1.
- FLUSH: lasts exactly 1 cycle, then REDIRECT.
  - err_in is ignored here, because flushed registers may glitch.
- REDIRECT: lasts exactly 1 cycle.
  - Outputs: pc_load=1, stall=1, flush=0. pc_target is stable.
  - Next state is GUARD; the guard counter loads GUARD_CYCLES.
  - err_in is ignored.
- GUARD: stall=0, flush=0. The guard counter decrements each cycle.
  - No error when the counter reaches 1: go to IDLE on that edge and clear the retry counter.
  - err_in != 0 in any GUARD cycle: treat it as a new accepted error (priority capture, err_count++) and increment the retry counter.
    - If the retry counter now exceeds MAX_RETRY, go to HALT.
    - Otherwise go to FLUSH.
- HALT:
  - fatal=1, stall=1, flush=1, recovering=1.
  - Held until reset; all inputs are ignored.
- Total latency from error detection to pc_load is 2 cycles: accept at edge N, flush during N+1, pc_load during N+2.
- Errors from several stages in the same cycle count once in err_count, and only the oldest stage's PC is used.
- Reset asserted mid-recovery aborts immediately to the reset values, with no flush pulse.
- When err_count is saturated, further accepted errors still trigger recovery.

Decomposition:
- Shared package contains:
  - state encoding (IDLE=0, FLUSH=1, REDIRECT=2, GUARD=3, HALT=4)
  - stage index constants STG_IFID=0, STG_IDEX=1, STG_EXMEM=2, STG_MEMWB=3
  - PC width constant 32
- One sub-module, razor_err_prio: combinational priority select from err_in/stage_pc to any_err plus sel_pc. It is reused by any future per-stage replay logic.

Test Plan:
1. err_in=4'b0100, stage_pc[2]=0x0000_0040 in IDLE -> flush high 1 cycle, pc_load high on the next cycle with pc_target=0x40, recovering low 2+GUARD_CYCLES cycles later, err_count=1.
2. err_in=4'b1010 with pc[3]=0x100 and pc[1]=0x108 -> pc_target=0x100, err_count increments by exactly 1.
3. Error pulse during FLUSH and during REDIRECT -> ignored: err_count unchanged, single pc_load.
4. New error in the 2nd GUARD cycle with pc=0x200 -> re-enter FLUSH, pc_target=0x200, retry=1; clean guard afterwards -> IDLE with retry cleared (check that a later error is not fatal).
5. Errors injected in every GUARD window for MAX_RETRY+1 consecutive recoveries -> fatal=1, stall=1, flush=1 held; further err_in ignored; fatal cleared only by reset.
6. Reset asserted asynchronously mid-GUARD (between edges) -> all outputs drop to 0 immediately; err_count is preloaded to 0xFFFF via force before an error -> stays 0xFFFF and recovery still occurs.
